// File: rtl/acc_rsp_adapter.sv
// Responder endpoint of the accelerator offload bus: forwards requests to an in-order core,
// remembers each request ID and returns tagged results. Perf counters: ACC_RSP_ADAPTER_PERF_EN.
module acc_rsp_adapter #(
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned IdWidth        = 3,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   slv_q_valid_i,
   output logic                   slv_q_ready_o,
   input  logic [31:0]            slv_q_instr_i,
   input  logic [3*DataWidth-1:0] slv_q_rs_i,
   input  logic [IdWidth-1:0]     slv_q_id_i,
   output logic                   slv_p_valid_o,
   input  logic                   slv_p_ready_i,
   output logic [DataWidth-1:0]   slv_p_data_o,
   output logic                   slv_p_error_o,
   output logic [IdWidth-1:0]     slv_p_id_o,
   output logic                   core_valid_o,
   input  logic                   core_ready_i,
   output logic [31:0]            core_instr_o,
   output logic [3*DataWidth-1:0] core_rs_o,
   input  logic                   core_res_valid_i,
   output logic                   core_res_ready_o,
   input  logic [DataWidth-1:0]   core_res_data_i,
   input  logic                   core_res_error_i,
   output logic [CntWidth-1:0]    outstanding_o,
   output logic                   proto_err_o
`ifdef ACC_RSP_ADAPTER_PERF_EN
   ,
   output logic [31:0]            perf_issued_o,
   output logic [31:0]            perf_stall_o
`endif
);

   localparam int unsigned         PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(MaxOutstanding - 1);
   localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);

   typedef enum logic [0:0] {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   logic [IdWidth-1:0]   id_mem_q [MaxOutstanding];
   logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0]  count_q, count_d;
   out_state_e           state_q, state_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 error_q, error_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic                 proto_err_q, proto_err_d;
   logic                 full_s, empty_s, issue_s, pop_s, p_valid_s, res_ready_s;

   // Issue path is a pure pass-through gated only by the FIFO occupancy.
   always_comb begin
      full_s        = (count_q == CntMax);
      empty_s       = (count_q == {CntWidth{1'b0}});
      core_valid_o  = slv_q_valid_i & ~full_s;
      slv_q_ready_o = core_ready_i & ~full_s;
      core_instr_o  = slv_q_instr_i;
      core_rs_o     = slv_q_rs_i;
      issue_s       = slv_q_valid_i & core_ready_i & ~full_s;
   end

   // Output-stage FSM outputs; a result is taken only when the head ID is valid.
   always_comb begin
      p_valid_s        = (state_q == OUT_FULL);
      res_ready_s      = ~empty_s & (~p_valid_s | slv_p_ready_i);
      pop_s            = core_res_valid_i & res_ready_s;
      slv_p_valid_o    = p_valid_s;
      core_res_ready_o = res_ready_s;
   end

   // Output-stage FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: begin
            if (pop_s) state_d = OUT_FULL;
            else       state_d = OUT_EMPTY;
         end
         OUT_FULL: begin
            if (pop_s)              state_d = OUT_FULL;
            else if (slv_p_ready_i) state_d = OUT_EMPTY;
            else                    state_d = OUT_FULL;
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   // ID FIFO bookkeeping, response payload capture and sticky protocol error.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
      error_d  = error_q;
      id_d     = id_q;
      if (issue_s) wr_ptr_d = (wr_ptr_q == PtrLast) ? {PtrWidth{1'b0}} : wr_ptr_q + PtrWidth'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? {PtrWidth{1'b0}} : rd_ptr_q + PtrWidth'(1);
         data_d   = core_res_data_i;
         error_d  = core_res_error_i;
         id_d     = id_mem_q[rd_ptr_q];
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({issue_s, pop_s})
         2'b10:   count_d = count_q + CntWidth'(1);
         2'b01:   count_d = count_q - CntWidth'(1);
         default: count_d = count_q;
      endcase
      proto_err_d = proto_err_q | (core_res_valid_i & empty_s);
   end

   // State and control registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= OUT_EMPTY;
         wr_ptr_q    <= {PtrWidth{1'b0}};
         rd_ptr_q    <= {PtrWidth{1'b0}};
         count_q     <= {CntWidth{1'b0}};
         data_q      <= {DataWidth{1'b0}};
         error_q     <= 1'b0;
         id_q        <= {IdWidth{1'b0}};
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_q      <= data_d;
         error_q     <= error_d;
         id_q        <= id_d;
         proto_err_q <= proto_err_d;
      end
   end

   // ID storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (issue_s) id_mem_q[wr_ptr_q] <= slv_q_id_i;
   end

   assign slv_p_data_o  = data_q;
   assign slv_p_error_o = error_q;
   assign slv_p_id_o    = id_q;
   assign outstanding_o = count_q;
   assign proto_err_o   = proto_err_q;

`ifdef ACC_RSP_ADAPTER_PERF_EN
   logic [31:0] perf_issued_q, perf_stall_q;

   // Free-running event counters, wrapping naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_issued_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else begin
         if (issue_s)                        perf_issued_q <= perf_issued_q + 32'd1;
         if (slv_q_valid_i & ~slv_q_ready_o) perf_stall_q  <= perf_stall_q + 32'd1;
      end
   end

   assign perf_issued_o = perf_issued_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_acc_rsp_adapter.sv
// Self-checking bench for acc_rsp_adapter: directed scenarios plus a randomized run
// compared against a queue-based model of in-flight IDs and the response slot.
module tb_acc_rsp_adapter;

   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        rst, q_valid, core_ready, res_valid, res_err, p_ready;
   logic [31:0] instr, res_data;
   logic [95:0] rs;
   logic [2:0]  q_id;
   logic        q_ready, p_valid, p_err, core_valid, res_ready, proto;
   logic [31:0] p_data, core_instr;
   logic [95:0] core_rs;
   logic [2:0]  p_id, outstanding;
`ifdef ACC_RSP_ADAPTER_PERF_EN
   logic [31:0] perf_issued, perf_stall;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Model: IDs in flight in issue order, plus the single response slot.
   logic [2:0]  m_ids[$];
   bit          m_pend;
   logic [31:0] m_data;
   bit          m_err;
   logic [2:0]  m_id;
   bit          m_proto;
   int unsigned m_issued, m_stall;

   acc_rsp_adapter #(.DataWidth(32), .IdWidth(3), .MaxOutstanding(MAX)) dut (
      .clk_i(clk), .rst_i(rst),
      .slv_q_valid_i(q_valid), .slv_q_ready_o(q_ready), .slv_q_instr_i(instr),
      .slv_q_rs_i(rs), .slv_q_id_i(q_id),
      .slv_p_valid_o(p_valid), .slv_p_ready_i(p_ready), .slv_p_data_o(p_data),
      .slv_p_error_o(p_err), .slv_p_id_o(p_id),
      .core_valid_o(core_valid), .core_ready_i(core_ready), .core_instr_o(core_instr),
      .core_rs_o(core_rs), .core_res_valid_i(res_valid), .core_res_ready_o(res_ready),
      .core_res_data_i(res_data), .core_res_error_i(res_err),
      .outstanding_o(outstanding), .proto_err_o(proto)
`ifdef ACC_RSP_ADAPTER_PERF_EN
      , .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic idle();
      q_valid = 1'b0; core_ready = 1'b0; res_valid = 1'b0; res_err = 1'b0; p_ready = 1'b0;
      q_id = 3'd0; instr = 32'd0; rs = 96'd0; res_data = 32'd0;
   endtask

   // Advance one clock and apply the rules of the adapter to the model.
   task automatic tick();
      int sz; bit qr, iss, racc;
      @(posedge clk);
      sz   = m_ids.size();
      qr   = core_ready && (sz < MAX);
      iss  = q_valid && qr;
      racc = res_valid && (sz > 0) && (!m_pend || p_ready);
      if (rst) begin
         m_ids.delete(); m_pend = 0; m_data = 32'd0; m_err = 0; m_id = 3'd0;
         m_proto = 0; m_issued = 0; m_stall = 0;
      end else begin
         if (res_valid && sz == 0) m_proto = 1;
         if (q_valid && !qr) m_stall++;
         if (iss) m_issued++;
         if (racc) begin
            m_pend = 1; m_data = res_data; m_err = res_err; m_id = m_ids.pop_front();
         end else if (m_pend && p_ready) begin
            m_pend = 0;
         end
         if (iss) m_ids.push_back(q_id);
      end
      @(negedge clk);
   endtask

   task automatic issue_ids(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         q_valid = 1'b1; core_ready = 1'b1; q_id = 3'(first + i); tick();
      end
      q_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      q_valid = 1'b0; p_ready = 1'b1;
      while ((m_ids.size() > 0 || m_pend) && guard < 40) begin
         res_valid = (m_ids.size() > 0); res_data = $urandom; res_err = 1'b0;
         tick(); guard++;
      end
      idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
      n_checks++;
      if ({p_valid, p_data, p_err, p_id, outstanding, proto} !== 41'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h err=%b id=%0d out=%0d proto=%b, expected all 0",
                  p_valid, p_data, p_err, p_id, outstanding, proto);
      end
      q_valid = 1'b1; core_ready = 1'b1; #1;
      n_checks++;
      if ({q_ready, core_valid, res_ready} !== 3'b110) begin
         n_errors++;
         $display("FAIL reset_handshake: got q_ready=%b core_valid=%b res_ready=%b, expected 1 1 0",
                  q_ready, core_valid, res_ready);
      end
      idle();
   endtask

   task automatic test_single_op();
      q_valid = 1'b1; core_ready = 1'b1; q_id = 3'd5; instr = $urandom; rs = {$urandom, $urandom, $urandom};
      #1;
      n_checks++;
      if (core_valid !== 1'b1 || core_instr !== instr || core_rs !== rs) begin
         n_errors++;
         $display("FAIL single_passthrough: got valid=%b instr=%h, expected 1 %h", core_valid, core_instr, instr);
      end
      tick(); idle();
      n_checks++;
      if (outstanding !== 3'd1) begin
         n_errors++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding);
      end
      res_valid = 1'b1; res_data = 32'hDEADBEEF; p_ready = 1'b1; #1;
      n_checks++;
      if (res_ready !== 1'b1) begin
         n_errors++; $display("FAIL single_res_ready: got %b expected 1", res_ready);
      end
      tick(); res_valid = 1'b0;
      n_checks++;
      if ({p_valid, p_data, p_id, p_err, outstanding} !== {1'b1, 32'hDEADBEEF, 3'd5, 1'b0, 3'd0}) begin
         n_errors++;
         $display("FAIL single_response: got v=%b data=%h id=%0d err=%b out=%0d, expected 1 deadbeef 5 0 0",
                  p_valid, p_data, p_id, p_err, outstanding);
      end
      tick();
      n_checks++;
      if (p_valid !== 1'b0) begin
         n_errors++; $display("FAIL single_release: got valid=%b expected 0", p_valid);
      end
      idle();
   endtask

   task automatic test_fill();
      issue_ids(1, 4);
      n_checks++;
      if (outstanding !== 3'd4) begin
         n_errors++; $display("FAIL fill_count: got %0d expected 4", outstanding);
      end
      q_valid = 1'b1; core_ready = 1'b1; q_id = 3'd5;
      res_valid = 1'b1; res_data = 32'h0000_1111; p_ready = 1'b1; #1;
      n_checks++;
      if ({q_ready, core_valid, res_ready} !== 3'b001) begin
         n_errors++;
         $display("FAIL fill_stall_with_pop: got q_ready=%b core_valid=%b res_ready=%b, expected 0 0 1",
                  q_ready, core_valid, res_ready);
      end
      tick(); res_valid = 1'b0; #1;
      n_checks++;
      if (q_ready !== 1'b1 || p_id !== 3'd1 || outstanding !== 3'd3) begin
         n_errors++;
         $display("FAIL fill_accept_next: got q_ready=%b id=%0d out=%0d, expected 1 1 3", q_ready, p_id, outstanding);
      end
      tick(); q_valid = 1'b0;
      n_checks++;
      if (outstanding !== 3'd4) begin
         n_errors++; $display("FAIL fill_refill: got %0d expected 4", outstanding);
      end
      drain();
   endtask

   task automatic test_backpressure();
      issue_ids(1, 3);
      res_valid = 1'b1; res_data = 32'h101; p_ready = 1'b0; tick();
      for (int c = 0; c < 5; c++) begin
         res_data = $urandom; #1;
         n_checks++;
         if ({res_ready, p_valid, p_id, p_data} !== {1'b0, 1'b1, 3'd1, 32'h101}) begin
            n_errors++;
            $display("FAIL backpressure_hold: cycle %0d got res_ready=%b v=%b id=%0d data=%h, expected 0 1 1 101",
                     c, res_ready, p_valid, p_id, p_data);
         end
         tick();
      end
      p_ready = 1'b1;
      for (int k = 2; k <= 3; k++) begin
         res_data = 32'h100 + 32'(k); tick();
         n_checks++;
         if ({p_valid, p_id, p_data} !== {1'b1, 3'(k), 32'h100 + 32'(k)}) begin
            n_errors++;
            $display("FAIL backpressure_order: got v=%b id=%0d data=%h, expected 1 %0d %h",
                     p_valid, p_id, p_data, k, 32'h100 + 32'(k));
         end
      end
      res_valid = 1'b0; tick();
      n_checks++;
      if (p_valid !== 1'b0 || outstanding !== 3'd0) begin
         n_errors++; $display("FAIL backpressure_end: got v=%b out=%0d expected 0 0", p_valid, outstanding);
      end
      idle();
   endtask

   task automatic test_error();
      issue_ids(1, 3);
      p_ready = 1'b1; res_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         res_err = (k == 2); res_data = $urandom; tick();
         n_checks++;
         if ({p_valid, p_id, p_err} !== {1'b1, 3'(k), 1'(k == 2)}) begin
            n_errors++;
            $display("FAIL error_passthrough: got v=%b id=%0d err=%b, expected 1 %0d %0d", p_valid, p_id, p_err, k, k == 2);
         end
      end
      res_valid = 1'b0; tick(); idle();
   endtask

   task automatic test_proto();
      n_checks++;
      if (proto !== 1'b0) begin
         n_errors++; $display("FAIL proto_initial: got %b expected 0", proto);
      end
      q_valid = 1'b1; core_ready = 1'b1; q_id = 3'd6; res_valid = 1'b1; res_data = 32'h66; p_ready = 1'b1; #1;
      n_checks++;
      if (res_ready !== 1'b0) begin
         n_errors++; $display("FAIL proto_empty_ready: got %b expected 0", res_ready);
      end
      tick(); q_valid = 1'b0; #1;
      n_checks++;
      if ({proto, outstanding, res_ready} !== {1'b1, 3'd1, 1'b1}) begin
         n_errors++;
         $display("FAIL proto_set: got proto=%b out=%0d res_ready=%b, expected 1 1 1", proto, outstanding, res_ready);
      end
      tick(); res_valid = 1'b0;
      n_checks++;
      if ({p_valid, p_id, p_data} !== {1'b1, 3'd6, 32'h66}) begin
         n_errors++; $display("FAIL proto_late_accept: got v=%b id=%0d data=%h, expected 1 6 66", p_valid, p_id, p_data);
      end
      tick(); tick(); tick();
      n_checks++;
      if (proto !== 1'b1) begin
         n_errors++; $display("FAIL proto_sticky: got %b expected 1", proto);
      end
      idle();
   endtask

   task automatic test_reset_midop();
      issue_ids(1, 3);
      res_valid = 1'b1; res_data = 32'h55; p_ready = 1'b0; tick(); res_valid = 1'b0;
      n_checks++;
      if (p_valid !== 1'b1 || outstanding !== 3'd2) begin
         n_errors++; $display("FAIL midop_setup: got v=%b out=%0d expected 1 2", p_valid, outstanding);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++;
      if ({p_valid, p_data, p_err, p_id, outstanding, proto} !== 41'd0) begin
         n_errors++;
         $display("FAIL midop_reset: got v=%b data=%h err=%b id=%0d out=%0d proto=%b, expected all 0",
                  p_valid, p_data, p_err, p_id, outstanding, proto);
      end
      issue_ids(7, 1);
      res_valid = 1'b1; res_data = 32'h77; p_ready = 1'b1; tick(); res_valid = 1'b0;
      n_checks++;
      if ({p_valid, p_id, p_data} !== {1'b1, 3'd7, 32'h77}) begin
         n_errors++; $display("FAIL midop_new_issue: got v=%b id=%0d data=%h, expected 1 7 77", p_valid, p_id, p_data);
      end
      tick(); idle();
   endtask

   task automatic test_random();
      int sz; bit full;
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         q_valid = $urandom_range(0, 1); q_id = 3'($urandom); core_ready = ($urandom_range(0, 3) != 0);
         instr = $urandom; rs = {$urandom, $urandom, $urandom};
         res_valid = (m_ids.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
         res_data = $urandom; res_err = $urandom_range(0, 1); p_ready = ($urandom_range(0, 2) != 0);
         #1;
         sz = m_ids.size(); full = (sz == MAX);
         n_checks++;
         if ({core_valid, q_ready, res_ready} !==
             {q_valid & !full, core_ready & !full, (sz > 0) & (!m_pend | p_ready)}) begin
            n_errors++;
            $display("FAIL random_handshake: cycle %0d got cv=%b qr=%b rr=%b with %0d in flight", c,
                     core_valid, q_ready, res_ready, sz);
         end
         n_checks++;
         if (core_instr !== instr || core_rs !== rs) begin
            n_errors++; $display("FAIL random_passthrough: cycle %0d got %h expected %h", c, core_instr, instr);
         end
         n_checks++;
         if ({p_valid, p_data, p_err, p_id, outstanding, proto} !==
             {m_pend, m_data, m_err, m_id, 3'(sz), m_proto}) begin
            n_errors++;
            $display("FAIL random_response: cycle %0d got v=%b d=%h e=%b id=%0d out=%0d pe=%b, expected %b %h %b %0d %0d %b",
                     c, p_valid, p_data, p_err, p_id, outstanding, proto, m_pend, m_data, m_err, m_id, sz, m_proto);
         end
`ifdef ACC_RSP_ADAPTER_PERF_EN
         n_checks++;
         if (perf_issued !== m_issued || perf_stall !== m_stall) begin
            n_errors++;
            $display("FAIL random_perf: got issued=%0d stall=%0d expected %0d %0d", perf_issued, perf_stall, m_issued, m_stall);
         end
`endif
         tick();
      end
      rst = 1'b0; idle();
   endtask

   initial begin
      rst = 1'b1; idle();
      test_reset();
      test_single_op();
      test_fill();
      test_backpressure();
      test_error();
      test_proto();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
